ecc_scrubber: RTL and testbench
===============================

# ecc_scrubber

Background scrub engine for the ECC-protected single-port RAM. On a start pulse it walks every address once, reading each stored SECDED codeword, decoding it, and writing back corrected codewords for single-bit errors. Double-bit errors are counted and reported, never written back. It sits beside the RAM as the read/correct side of the write-path encoder, and shares the RAM port through the memory interface below.

## Interface
- DATA_WIDTH, 8, data bits per word (4..32)
- ADDR_WIDTH, 4, RAM address width; the sweep covers 2^ADDR_WIDTH entries
- CNT_WIDTH, 16, width of the error counters
- clk  in  1  clock; all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a sweep; honoured only in IDLE
- busy  out  1  high while a sweep is in progress
- done  out  1  one-cycle pulse when a sweep completes
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_re  out  1  read strobe
- mem_we  out  1  write strobe
- mem_wdata  out  CW_WIDTH  corrected codeword
- mem_rdata  in  CW_WIDTH  codeword, valid one cycle after mem_re
- corr_cnt  out  CNT_WIDTH  corrected single-bit errors, saturating
- uncorr_cnt  out  CNT_WIDTH  detected double-bit errors, saturating
- uncorr_valid  out  1  sticky: at least one uncorrectable error this sweep
- uncorr_addr  out  ADDR_WIDTH  address of the first uncorrectable error

## Operation
- Codeword layout: CW_WIDTH = R + DATA_WIDTH + 1, where R is the smallest value with 2^R >= DATA_WIDTH + R + 1 (13 bits for DATA_WIDTH = 8).
  - Hamming positions 1..CW_WIDTH-1 hold the check bits at powers of two and the data bits in ascending order elsewhere.
  - Bit 0 is the overall parity bit, chosen so the whole codeword has even parity.
- Decode: s = Hamming syndrome, p = XOR of all codeword bits.
  - s=0, p=0: clean.
  - p=1, s=0: bit 0 is in error; correctable.
  - p=1, 0<s<CW_WIDTH: bit s is in error; correctable.
  - p=1, s>=CW_WIDTH: uncorrectable.
  - p=0, s!=0: double error; uncorrectable.
- FSM states: IDLE, RD, DEC, WB.
  - IDLE: on start, clear the counters, uncorr_valid and uncorr_addr; set address 0; go to RD.
  - RD: drive mem_addr and set mem_re=1; go to DEC.
  - DEC: decode mem_rdata. A correctable error increments corr_cnt and goes to WB. An uncorrectable error increments uncorr_cnt; if uncorr_valid is 0, it also captures the address and sets uncorr_valid. Otherwise the FSM advances.
  - WB: drive mem_we=1 with mem_wdata = the corrected codeword at the same address, then advance.
  - Advance: if the address is the last one, pulse done and go to IDLE; otherwise increment the address and go to RD.
- Counters saturate at all-ones and never wrap.
- start while busy is ignored. start in the same cycle as the done pulse is ignored; it is honoured from the next cycle.
- mem_re and mem_we are never high in the same cycle. mem_wdata is 0 whenever mem_we=0.

## Timing
- Reset values: busy=0, done=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, corr_cnt=0, uncorr_cnt=0, uncorr_valid=0, uncorr_addr=0; state IDLE.
- start is sampled in cycle T; busy=1 and RD are active in cycle T+1.
- Per address, a clean or uncorrectable word takes 2 cycles (RD, DEC). A correctable word takes 3 cycles (RD, DEC, WB).
- A clean sweep takes 2*2^ADDR_WIDTH cycles. done is high in the cycle after the last DEC or WB, together with busy=0.
- The counters and uncorr_* are valid when done is high and hold their values until the next accepted start.
- rst mid-sweep aborts on the next edge. No further mem_we is issued and all outputs return to their reset values.

## Configuration
- ECC_SCRUB_WRITEBACK_EN defined: behaviour as above; correctable words are rewritten in WB.
- ECC_SCRUB_WRITEBACK_EN undefined: report-only mode.
  - The WB state is absent and mem_we is tied to 0.
  - Correctable errors are still counted.
  - Every address takes 2 cycles.

## Structure
- Package ecc_pkg holds:
  - the CW_WIDTH and R computation as constant functions;
  - the encode function;
  - the FSM state enum;
  - the decode-result enum (CLEAN, CORR, UNCORR).
- Sub-module ecc_secded_dec: a combinational decoder (codeword in; corrected codeword, corrected data and result out). The scrubber instantiates it in DEC.

## Test plan
- All 16 entries hold encode(0xA5); start -> done exactly 32 cycles after busy rises; corr_cnt=0, uncorr_cnt=0, mem_we never asserted.
- Entry 3 = encode(0xA5) with bit 5 flipped -> corr_cnt=1; one mem_we at mem_addr=3 with mem_wdata=encode(0xA5); sweep takes 33 cycles.
- Entry 7 with bits 2 and 9 flipped, entry 12 with bits 1 and 4 flipped -> uncorr_cnt=2, uncorr_valid=1, uncorr_addr=7, no mem_we.
- Entry 0 with only bit 0 flipped -> classified correctable; rewritten with encode(data) at mem_addr=0.
- rst asserted in the WB cycle at entry 5 -> mem_we=0 on the next cycle; all outputs at reset values; a new start sweeps from address 0.
- Build without ECC_SCRUB_WRITEBACK_EN using the stimulus of the entry-3 test -> corr_cnt=1, mem_we never asserted, sweep takes 32 cycles.

Source files
------------

// File: rtl/ecc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ecc_pkg: SECDED widths, encoder and shared enums for the ECC scrubber
// Revision: 1.0
// ----------------------------------------------------------------------------
package ecc_pkg;

   localparam int MAX_DATA_WIDTH = 32;
   localparam int MAX_CW_WIDTH   = 39;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      DEC  = 2'd2,
      WB   = 2'd3
   } scrub_state_e;

   typedef enum logic [1:0] {
      CLEAN  = 2'd0,
      CORR   = 2'd1,
      UNCORR = 2'd2
   } dec_result_e;

   // Smallest R with 2^R >= data_width + R + 1.
   function automatic int ecc_r_width(input int data_width);
      int r;
      r = 0;
      for (int i = 6; i >= 1; i--) begin
         if ((1 << i) >= data_width + i + 1) r = i;
      end
      return r;
   endfunction

   function automatic int ecc_cw_width(input int data_width);
      return ecc_r_width(data_width) + data_width + 1;
   endfunction

   function automatic bit ecc_is_pow2(input int p);
      return (p != 0) && ((p & (p - 1)) == 0);
   endfunction

   function automatic int ecc_data_pos(input int k);
      int cnt;
      int pos;
      cnt = 0;
      pos = 0;
      for (int p = 1; p < MAX_CW_WIDTH; p++) begin
         if (!ecc_is_pow2(p)) begin
            if (cnt == k && pos == 0) pos = p;
            cnt++;
         end
      end
      return pos;
   endfunction

   function automatic logic [MAX_CW_WIDTH-1:0] ecc_encode(
      input logic [MAX_DATA_WIDTH-1:0] data,
      input int                        data_width
   );
      logic [MAX_CW_WIDTH-1:0] cw;
      logic                    par;
      int                      r;
      int                      cw_w;
      cw   = '0;
      r    = ecc_r_width(data_width);
      cw_w = ecc_cw_width(data_width);
      for (int k = 0; k < MAX_DATA_WIDTH; k++) begin
         if (k < data_width) cw[ecc_data_pos(k)] = data[k];
      end
      for (int i = 0; i < 6; i++) begin
         if (i < r) begin
            par = 1'b0;
            for (int p = 1; p < MAX_CW_WIDTH; p++) begin
               if (p < cw_w && (p & (1 << i)) != 0) par = par ^ cw[p];
            end
            cw[1 << i] = par;
         end
      end
      cw[0] = ^cw;
      return cw;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_secded_dec.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ecc_secded_dec: combinational SECDED decoder (corrects 1 bit, detects 2)
// Revision: 1.0
// ----------------------------------------------------------------------------
module ecc_secded_dec
   import ecc_pkg::*;
#(
   parameter int  DATA_WIDTH = 8,
   localparam int R_WIDTH    = ecc_r_width(DATA_WIDTH),
   localparam int CW_WIDTH   = ecc_cw_width(DATA_WIDTH)
) (
   input  logic [CW_WIDTH-1:0]   codeword,
   output logic [CW_WIDTH-1:0]   corr_codeword,
   output logic [DATA_WIDTH-1:0] corr_data,
   output logic [1:0]            result
);

   logic [R_WIDTH-1:0]  syndrome;
   logic                parity;
   logic [CW_WIDTH-1:0] flip_mask;

   always_comb begin
      syndrome = '0;
      for (int p = 1; p < CW_WIDTH; p++) begin
         if (codeword[p]) syndrome = syndrome ^ R_WIDTH'(p);
      end
   end

   assign parity = ^codeword;

   // A zero syndrome with odd parity points at the overall parity bit itself.
   always_comb begin
      flip_mask = '0;
      result    = CLEAN;
      if (!parity) begin
         if (syndrome != '0) result = UNCORR;
      end else if (int'(syndrome) < CW_WIDTH) begin
         result    = CORR;
         flip_mask = CW_WIDTH'(1) << syndrome;
      end else begin
         result = UNCORR;
      end
   end

   assign corr_codeword = codeword ^ flip_mask;

   for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_data
      assign corr_data[k] = corr_codeword[ecc_data_pos(k)];
   end

endmodule
`default_nettype wire

// File: rtl/ecc_scrubber.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ecc_scrubber: sweeps the RAM, counts SECDED errors and (with
// ECC_SCRUB_WRITEBACK_EN defined) rewrites correctable words.
// Revision: 1.0
// ----------------------------------------------------------------------------
module ecc_scrubber
   import ecc_pkg::*;
#(
   parameter int  DATA_WIDTH = 8,
   parameter int  ADDR_WIDTH = 4,
   parameter int  CNT_WIDTH  = 16,
   localparam int CW_WIDTH   = ecc_cw_width(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic [CW_WIDTH-1:0]   mem_wdata,
   input  logic [CW_WIDTH-1:0]   mem_rdata,
   output logic [CNT_WIDTH-1:0]  corr_cnt,
   output logic [CNT_WIDTH-1:0]  uncorr_cnt,
   output logic                  uncorr_valid,
   output logic [ADDR_WIDTH-1:0] uncorr_addr
);

   scrub_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CNT_WIDTH-1:0]  corr_cnt_q, corr_cnt_d;
   logic [CNT_WIDTH-1:0]  uncorr_cnt_q, uncorr_cnt_d;
   logic                  uncorr_valid_q, uncorr_valid_d;
   logic [ADDR_WIDTH-1:0] uncorr_addr_q, uncorr_addr_d;
   logic                  done_q, done_d;
   logic                  advance;
   logic                  last_addr;

   logic [CW_WIDTH-1:0]   dec_codeword;
   logic [DATA_WIDTH-1:0] dec_data;
   logic [1:0]            dec_result_raw;
   dec_result_e           dec_result;
   logic                  unused_dec;

`ifdef ECC_SCRUB_WRITEBACK_EN
   logic [CW_WIDTH-1:0]   wdata_q, wdata_d;
`endif

   ecc_secded_dec #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_dec (
      .codeword      (mem_rdata),
      .corr_codeword (dec_codeword),
      .corr_data     (dec_data),
      .result        (dec_result_raw)
   );

   assign dec_result = dec_result_e'(dec_result_raw);
   assign last_addr  = (addr_q == '1);

`ifdef ECC_SCRUB_WRITEBACK_EN
   assign unused_dec = ^dec_data;
`else
   assign unused_dec = ^{dec_data, dec_codeword};
`endif

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      corr_cnt_d     = corr_cnt_q;
      uncorr_cnt_d   = uncorr_cnt_q;
      uncorr_valid_d = uncorr_valid_q;
      uncorr_addr_d  = uncorr_addr_q;
      done_d         = 1'b0;
      advance        = 1'b0;
`ifdef ECC_SCRUB_WRITEBACK_EN
      wdata_d        = wdata_q;
`endif
      case (state_q)
         // A start coinciding with the done pulse is dropped on purpose.
         IDLE: begin
            if (start && !done_q) begin
               corr_cnt_d     = '0;
               uncorr_cnt_d   = '0;
               uncorr_valid_d = 1'b0;
               uncorr_addr_d  = '0;
               addr_d         = '0;
               state_d        = RD;
            end
         end
         RD: state_d = DEC;
         DEC: begin
            advance = 1'b1;
            case (dec_result)
               CORR: begin
                  corr_cnt_d = sat_inc(corr_cnt_q);
`ifdef ECC_SCRUB_WRITEBACK_EN
                  wdata_d = dec_codeword;
                  state_d = WB;
                  advance = 1'b0;
`endif
               end
               UNCORR: begin
                  uncorr_cnt_d = sat_inc(uncorr_cnt_q);
                  if (!uncorr_valid_q) begin
                     uncorr_valid_d = 1'b1;
                     uncorr_addr_d  = addr_q;
                  end
               end
               default: ;
            endcase
         end
`ifdef ECC_SCRUB_WRITEBACK_EN
         WB: advance = 1'b1;
`endif
         default: state_d = IDLE;
      endcase

      if (advance) begin
         if (last_addr) begin
            done_d  = 1'b1;
            addr_d  = '0;
            state_d = IDLE;
         end else begin
            addr_d  = addr_q + 1'b1;
            state_d = RD;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         addr_q         <= '0;
         corr_cnt_q     <= '0;
         uncorr_cnt_q   <= '0;
         uncorr_valid_q <= 1'b0;
         uncorr_addr_q  <= '0;
         done_q         <= 1'b0;
`ifdef ECC_SCRUB_WRITEBACK_EN
         wdata_q        <= '0;
`endif
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         corr_cnt_q     <= corr_cnt_d;
         uncorr_cnt_q   <= uncorr_cnt_d;
         uncorr_valid_q <= uncorr_valid_d;
         uncorr_addr_q  <= uncorr_addr_d;
         done_q         <= done_d;
`ifdef ECC_SCRUB_WRITEBACK_EN
         wdata_q        <= wdata_d;
`endif
      end
   end

   assign busy         = (state_q != IDLE);
   assign done         = done_q;
   assign mem_addr     = addr_q;
   assign mem_re       = (state_q == RD);
   assign corr_cnt     = corr_cnt_q;
   assign uncorr_cnt   = uncorr_cnt_q;
   assign uncorr_valid = uncorr_valid_q;
   assign uncorr_addr  = uncorr_addr_q;

`ifdef ECC_SCRUB_WRITEBACK_EN
   assign mem_we    = (state_q == WB);
   assign mem_wdata = mem_we ? wdata_q : '0;
`else
   assign mem_we    = 1'b0;
   assign mem_wdata = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ecc_scrubber.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ecc_scrubber: randomized scoreboard bench for ecc_scrubber
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_ecc_scrubber;

   localparam int DW      = 8;
   localparam int AW      = 4;
   localparam int CNTW    = 3;
   localparam int CNT_MAX = 7;
   localparam int CWW     = 13;
   localparam int NENT    = 16;
`ifdef ECC_SCRUB_WRITEBACK_EN
   localparam bit WB_EN = 1'b1;
`else
   localparam bit WB_EN = 1'b0;
`endif

   typedef struct {
      int corr;
      int uncorr;
      int uv;
      int ua;
      int cycles;
   } sweep_exp_t;

   typedef struct {
      int             addr;
      logic [CWW-1:0] data;
   } wr_exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            busy;
   logic            done;
   logic [AW-1:0]   mem_addr;
   logic            mem_re;
   logic            mem_we;
   logic [CWW-1:0]  mem_wdata;
   logic [CWW-1:0]  mem_rdata;
   logic [CNTW-1:0] corr_cnt;
   logic [CNTW-1:0] uncorr_cnt;
   logic            uncorr_valid;
   logic [AW-1:0]   uncorr_addr;

   logic [CWW-1:0]  mem  [NENT];
   logic [CWW-1:0]  img  [NENT];
   logic [CWW-1:0]  gold [NENT];
   logic [CWW-1:0]  post [NENT];
   int              nflip[NENT];
   logic            load_req;

   sweep_exp_t sweep_q[$];
   wr_exp_t    wr_q[$];
   int         checks = 0;
   int         errors = 0;

   ecc_scrubber #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .CNT_WIDTH  (CNTW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .mem_addr     (mem_addr),
      .mem_re       (mem_re),
      .mem_we       (mem_we),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .corr_cnt     (corr_cnt),
      .uncorr_cnt   (uncorr_cnt),
      .uncorr_valid (uncorr_valid),
      .uncorr_addr  (uncorr_addr)
   );

   always #5 clk = ~clk;

   // Single-port RAM with one-cycle read latency; load_req copies the staged image in.
   always @(posedge clk) begin
      if (mem_re) mem_rdata <= mem[mem_addr];
      if (load_req) begin
         for (int i = 0; i < NENT; i++) mem[i] <= img[i];
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [CWW-1:0] tb_encode(input logic [DW-1:0] d);
      int             dpos[DW];
      logic [CWW-1:0] w;
      logic           par;
      dpos = '{3, 5, 6, 7, 9, 10, 11, 12};
      w = '0;
      for (int k = 0; k < DW; k++) w[dpos[k]] = d[k];
      for (int c = 1; c <= 8; c = c * 2) begin
         par = 1'b0;
         for (int p = 1; p < CWW; p++) begin
            if ((p & c) != 0 && p != c) par = par ^ w[p];
         end
         w[c] = par;
      end
      w[0] = ^w;
      return w;
   endfunction

   task automatic set_entry(input int i, input logic [DW-1:0] d, input int nf,
                            input int b0, input int b1);
      gold[i]  = tb_encode(d);
      img[i]   = gold[i];
      nflip[i] = nf;
      if (nf >= 1) img[i][b0] = ~img[i][b0];
      if (nf >= 2) img[i][b1] = ~img[i][b1];
   endtask

   task automatic set_entry_rand(input int i, input logic [DW-1:0] d, input int nf);
      int b0;
      int b1;
      b0 = int'($urandom_range(0, CWW - 1));
      b1 = (b0 + int'($urandom_range(1, CWW - 1))) % CWW;
      set_entry(i, d, nf, b0, b1);
   endtask

   // 0 flips: clean; 1 flip: correctable, rewritten with the golden word; 2 flips: uncorrectable.
   task automatic build_expect();
      sweep_exp_t e;
      wr_exp_t    w;
      e.corr = 0; e.uncorr = 0; e.uv = 0; e.ua = 0; e.cycles = 0;
      for (int i = 0; i < NENT; i++) begin
         post[i] = img[i];
         e.cycles += 2;
         if (nflip[i] == 1) begin
            e.corr++;
            if (WB_EN) begin
               e.cycles += 1;
               post[i] = gold[i];
               w.addr  = i;
               w.data  = gold[i];
               wr_q.push_back(w);
            end
         end else if (nflip[i] == 2) begin
            e.uncorr++;
            if (e.uv == 0) begin
               e.uv = 1;
               e.ua = i;
            end
         end
      end
      if (e.corr > CNT_MAX) e.corr = CNT_MAX;
      if (e.uncorr > CNT_MAX) e.uncorr = CNT_MAX;
      sweep_q.push_back(e);
   endtask

   task automatic load_image();
      @(negedge clk);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {busy, done, mem_re, mem_we, mem_addr, mem_wdata,
                   corr_cnt, uncorr_cnt, uncorr_valid, uncorr_addr}, 64'd0);
   endtask

   task automatic run_sweep(input bit poke_busy, input bit poke_done);
      int n;
      int bad;
      load_image();
      build_expect();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      n = 0;
      while (!done && n < 300) begin
         @(negedge clk);
         n++;
         start = (poke_busy && n == 5);
      end
      start = 1'b0;
      if (!done) begin
         check("sweep_timeout", 0, 1);
         sweep_q.delete();
         wr_q.delete();
      end else begin
         if (poke_done) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("start_at_done_ignored", {busy, done}, 0);
         end else begin
            @(negedge clk);
         end
         bad = 0;
         for (int i = 0; i < NENT; i++) if (mem[i] !== post[i]) bad++;
         check("mem_image_mismatches", bad, 0);
      end
      check("write_queue_drained", wr_q.size(), 0);
   endtask

   // Scoreboard monitor: pops expectations whenever the DUT presents a write or done.
   initial begin
      int         cyc;
      int         rise_cyc;
      int         exp_rd;
      logic       busy_prev;
      sweep_exp_t e;
      wr_exp_t    w;
      cyc = 0; rise_cyc = 0; exp_rd = 0; busy_prev = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (busy === 1'b1 && busy_prev !== 1'b1) begin
            rise_cyc = cyc;
            exp_rd   = 0;
         end
         busy_prev = busy;
         check("re_we_exclusive", mem_re & mem_we, 0);
         if (mem_we !== 1'b1) check("wdata_zero_when_idle", mem_wdata, 0);
         if (mem_re === 1'b1) begin
            check("read_addr", mem_addr, exp_rd);
            exp_rd++;
         end
         if (mem_we === 1'b1) begin
            if (wr_q.size() == 0) begin
               check("unexpected_write_addr", mem_addr, 64'hFFFF);
            end else begin
               w = wr_q.pop_front();
               check("write_addr", mem_addr, w.addr);
               check("write_data", mem_wdata, w.data);
            end
         end
         if (done === 1'b1) begin
            if (sweep_q.size() == 0) begin
               check("unexpected_done", done, 0);
            end else begin
               e = sweep_q.pop_front();
               check("corr_cnt", corr_cnt, e.corr);
               check("uncorr_cnt", uncorr_cnt, e.uncorr);
               check("uncorr_valid", uncorr_valid, e.uv);
               if (e.uv != 0) check("uncorr_addr", uncorr_addr, e.ua);
               check("busy_at_done", busy, 0);
               check("sweep_cycles", cyc - rise_cyc, e.cycles);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [38:0]   pe;
      logic [DW-1:0] d;
      int            n;
      rst = 1'b1;
      start = 1'b0;
      load_req = 1'b0;
      for (int i = 0; i < NENT; i++) set_entry(i, 8'h00, 0, 0, 0);
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_state");
      rst = 1'b0;

      for (int t = 0; t < 4; t++) begin
         d  = DW'($urandom);
         pe = ecc_pkg::ecc_encode(32'(d), DW);
         check("pkg_encode", pe[CWW-1:0], tb_encode(d));
      end

      // All clean, then a start on the done cycle.
      for (int i = 0; i < NENT; i++) set_entry(i, 8'hA5, 0, 0, 0);
      run_sweep(1'b0, 1'b1);

      // Entry 3 bit 5 flipped, with a start while busy.
      set_entry(3, 8'hA5, 1, 5, 0);
      run_sweep(1'b1, 1'b0);

      // Double errors at 7 and 12.
      for (int i = 0; i < NENT; i++) set_entry(i, 8'hA5, 0, 0, 0);
      set_entry(7, 8'hA5, 2, 2, 9);
      set_entry(12, 8'hA5, 2, 1, 4);
      run_sweep(1'b0, 1'b0);

      // Overall parity bit only.
      for (int i = 0; i < NENT; i++) set_entry(i, DW'($urandom), 0, 0, 0);
      set_entry(0, 8'h3C, 1, 0, 0);
      run_sweep(1'b0, 1'b0);

      // Abort with rst while entry 5 is being handled.
      for (int i = 0; i < NENT; i++) set_entry(i, DW'($urandom), 0, 0, 0);
      set_entry(5, 8'h5A, 1, 7, 0);
      load_image();
      if (WB_EN) begin
         wr_q.push_back('{addr: 5, data: gold[5]});
      end
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(((WB_EN && mem_we === 1'b1) || (!WB_EN && mem_re === 1'b1)) && mem_addr == 4'd5)
             && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("abort_point_reached", n < 100, 1);
      #1 rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("reset_after_abort");
      rst = 1'b0;
      check("abort_writes_drained", wr_q.size(), 0);
      wr_q.delete();
      sweep_q.delete();

      // Fresh sweep after abort must start at address 0.
      for (int i = 0; i < NENT; i++) set_entry(i, DW'($urandom), 0, 0, 0);
      run_sweep(1'b0, 1'b0);

      // Saturation: every entry correctable, then every entry uncorrectable.
      for (int i = 0; i < NENT; i++) set_entry_rand(i, DW'($urandom), 1);
      run_sweep(1'b0, 1'b0);
      for (int i = 0; i < NENT; i++) set_entry_rand(i, DW'($urandom), 2);
      run_sweep(1'b0, 1'b0);

      for (int s = 0; s < 8; s++) begin
         for (int i = 0; i < NENT; i++) begin
            n = int'($urandom_range(0, 3));
            set_entry_rand(i, DW'($urandom), (n == 3) ? 2 : (n == 2) ? 1 : 0);
         end
         run_sweep(s[0], s[1]);
      end

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
